booth_mul_seq: RTL
==================

# booth_mul_seq

Parametrised, iterative radix-2 Booth multiplier with a valid/ready handshake on both sides. It computes one WIDTH×WIDTH product, selectable signed or unsigned, by performing one Booth step per clock. It replaces the combinational 16-bit Booth unit wherever a small-area, multi-cycle multiplier is acceptable, such as the polynomial/finite-field datapath front ends.

## Interface
- WIDTH, 16, operand width in bits (≥4); the product is 2*WIDTH bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  block can accept operands (high only in IDLE).
- x  in  WIDTH  multiplicand.
- y  in  WIDTH  multiplier.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with x/y.
- out_valid  out  1  product available.
- out_ready  in  1  consumer accepts product.
- z  out  2*WIDTH  product; held stable while out_valid=1.
- busy  out  1  high in RUN or DONE.

## Operation
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, busy=0, z=0, and all internal registers = 0.
- Accept: when in IDLE with in_valid=1 at a clock edge:
  - Load M = x extended to WIDTH+2 bits: sign-extended if is_signed, else zero-extended.
  - Load Q = y extended to WIDTH+1 bits by the same rule.
  - A=0 (WIDTH+2 bits), q_1=0, cnt=0; go to RUN.
- RUN: each edge performs one Booth step:
  - {Q[0],q_1}=10 → A=A−M; 01 → A=A+M; 00/11 → no change.
  - Then arithmetic shift right of the {A,Q,q_1} concatenation by 1, with A's MSB replicated.
  - cnt increments each step. After step WIDTH+1 (cnt reaches WIDTH), go to DONE.
- The extra operand bit lets one datapath serve both modes. All arithmetic is modulo 2^(WIDTH+2) in A and cannot overflow.
- DONE: z = low 2*WIDTH bits of {A,Q}, registered on entry to DONE, and out_valid=1.
  - out_valid is held with z stable until out_ready=1 at an edge, then the block returns to IDLE.
  - in_ready=0 throughout DONE; no operand acceptance in the same cycle as the product is consumed.
- Changes on in_valid, x, y or is_signed outside the accepting edge are ignored.
- Reset mid-operation: an asserted rst aborts RUN or DONE immediately. No out_valid pulse is produced for the aborted operation.

## Timing
- Latency: out_valid rises after exactly WIDTH+1 rising edges following the accepting edge (17 for WIDTH=16).
- Throughput: one product per WIDTH+3 cycles when out_ready is held high.
  - Consuming edge → IDLE; next edge may accept.
- in_ready is combinational from state only (IDLE), with no path from in_valid.
- out_valid and z are registered.
- busy = (state≠IDLE), registered through state.
- cnt width is clog2(WIDTH+1).
- An out_ready=1 seen during IDLE or RUN has no effect.

## Test plan
- WIDTH=16, signed, x=−3 (0xFFFD), y=7 → z=0xFFFFFFEB; out_valid appears 17 edges after acceptance.
- WIDTH=16, unsigned, x=y=0xFFFF → z=0xFFFE0001; the same operands in signed mode → z=0x00000001.
- WIDTH=16, signed corner cases:
  - 0x8000×0x8000 → 0x40000000.
  - 0x8000×0x7FFF → 0xC0008000.
  - 0×0x8000 → 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required: z is stable, in_ready=0, and a second in_valid is not accepted. After the out_ready pulse, the block returns to IDLE and the next operand pair is accepted one edge later.
- Reset: assert rst asynchronously mid-RUN (cnt=5). Required: all outputs return to reset values at once with no clock edge needed; after release, a fresh 5×6 (signed) → 30.
- WIDTH=8: exhaustive 65536 operand pairs × both modes against a reference product, with out_ready randomised.

Source files
------------

// File: rtl/booth_mul_seq_if.sv
// Operand/product handshake bundle for booth_mul_seq.
// The master side presents operands and consumes products; the slave side is the multiplier.
interface booth_mul_seq_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               is_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] z;
  logic               busy;

  modport master (
    output in_valid, x, y, is_signed, out_ready,
    input  in_ready, out_valid, z, busy
  );

  modport slave (
    input  in_valid, x, y, is_signed, out_ready,
    output in_ready, out_valid, z, busy
  );
endinterface

// File: rtl/booth_mul_seq.sv
// Iterative radix-2 Booth multiplier, one Booth step per clock, signed or unsigned operands.
// Operands are widened by one bit so a single signed datapath handles both modes.
module booth_mul_seq #(
  parameter int unsigned WIDTH = 16
) (
  input logic             clk,
  input logic             rst,
  booth_mul_seq_if.slave  bus
);

  localparam int unsigned AW = WIDTH + 2;
  localparam int unsigned QW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     a_q, a_d, m_q, m_d;
  logic [QW-1:0]     q_q, q_d;
  logic              q1_q, q1_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] z_q, z_d;

  logic [AW-1:0]     sum;
  logic [AW-1:0]     a_step;
  logic [QW-1:0]     q_step;
  logic [AW+QW-1:0]  aq_step;

  // Booth add/subtract followed by arithmetic shift of {A,Q,q_1}
  always_comb begin
    sum = a_q;
    unique case ({q_q[0], q1_q})
      2'b10:   sum = a_q - m_q;
      2'b01:   sum = a_q + m_q;
      default: sum = a_q;
    endcase
    a_step  = {sum[AW-1], sum[AW-1:1]};
    q_step  = {sum[0], q_q[QW-1:1]};
    aq_step = {a_step, q_step};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          m_d     = bus.is_signed ? {{2{bus.x[WIDTH-1]}}, bus.x} : {2'b00, bus.x};
          q_d     = bus.is_signed ? {bus.y[WIDTH-1], bus.y} : {1'b0, bus.y};
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d   = a_step;
        q_d   = q_step;
        q1_d  = q_q[0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH)) begin
          z_d     = aq_step[2*WIDTH-1:0];
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.z         = z_q;

endmodule
